serial_addsub: RTL

Parametrised bit-serial adder/subtractor: successor to the single-bit full adder built from half subtractors. Operands of WIDTH bits are captured on a start pulse and processed LSB-first, one bit per clock, through a single 1-bit add/sub cell with a registered carry/borrow. The block is for area-constrained datapaths where WIDTH-cycle latency is acceptable.

---
 rtl/serial_addsub_pkg.sv | 17 +
 rtl/addsub_bit_cell.sv | 23 ++
 rtl/serial_addsub.sv | 89 ++++++++
 3 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/addsub_bit_cell.sv
// Combinational 1-bit add/sub cell: two cascaded half subtractors with mode-gated carry/borrow.
module addsub_bit_cell
    import serial_addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic mode,
    output logic s,
    output logic co
);

    logic d1, bo1, bo2;

    assign d1  = a ^ b;
    assign bo1 = ~a & b;
    assign s   = d1 ^ c;
    assign bo2 = ~d1 & c;

    // The difference bit equals the sum bit, so only the carry term depends on mode.
    assign co = (mode == MODE_SUB) ? (bo1 | bo2) : ((a & b) | (d1 & c));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock.
// Define SERIAL_ADDSUB_OVF_EN to add the signed-overflow output ovf.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [CW-1:0]    cnt;
    logic             c, mode_r;
    logic             s, co, last;

    addsub_bit_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .c    (c),
        .mode (mode_r),
        .s    (s),
        .co   (co)
    );

    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            cnt    <= '0;
            c      <= 1'b0;
            mode_r <= MODE_ADD;
            result <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= {s, r_sh[WIDTH-1:1]};
            c    <= co;
            cnt  <= cnt + CW'(1);
            if (last) begin
                result <= {s, r_sh[WIDTH-1:1]};
                cout   <= co;
`ifdef SERIAL_ADDSUB_OVF_EN
                // c is the carry into the MSB at this point, co the carry out of it.
                ovf    <= c ^ co;
`endif
                state  <= DONE;
            end
        end else if (start) begin
            // Reached from IDLE or DONE; DONE+start gives back-to-back operation.
            a_sh   <= a;
            b_sh   <= b;
            c      <= cin;
            mode_r <= mode;
            cnt    <= '0;
            state  <= RUN;
        end else begin
            state <= IDLE;
        end
    end

endmodule
